// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light controller.
//   - Lamp codes driven per approach on o_light.
//   - Phase encoding used for the controller state and o_phase.
//   - LIGHT_W: width of one approach's lamp code.
package tl_pkg;

    localparam int unsigned LIGHT_W = 2;

    localparam logic [LIGHT_W-1:0] LIGHT_GREEN  = 2'b00;
    localparam logic [LIGHT_W-1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [LIGHT_W-1:0] LIGHT_RED    = 2'b10;

    typedef enum logic [1:0] {
        PH_GREEN   = 2'd0,
        PH_YELLOW  = 2'd1,
        PH_ALL_RED = 2'd2
    } phase_t;

endpackage : tl_pkg

// File: rtl/tl_rr_next.sv
// Round-robin next-approach selector (purely combinational).
// Ports:
//   i_traffic [N_DIR-1:0]        car-present per approach
//   cur_dir   [$clog2(N_DIR)-1:0] approach currently served
//   next_dir  [$clog2(N_DIR)-1:0] first busy approach after cur_dir
//                                 (wrapping, cur_dir excluded); if none
//                                 is busy, (cur_dir+1) mod N_DIR
module tl_rr_next #(
    parameter int unsigned N_DIR = 2
) (
    input  logic [N_DIR-1:0]         i_traffic,
    input  logic [$clog2(N_DIR)-1:0] cur_dir,
    output logic [$clog2(N_DIR)-1:0] next_dir
);

    localparam int unsigned DIR_W = $clog2(N_DIR);

    logic        found;
    logic [31:0] idx;

    // Scan cur_dir+1 .. cur_dir+N_DIR-1; the current approach is never a candidate.
    always_comb begin
        next_dir = DIR_W'((32'(cur_dir) + 32'd1) % N_DIR);
        found    = 1'b0;
        idx      = '0;
        for (int unsigned k = 1; k < N_DIR; k++) begin
            idx = (32'(cur_dir) + k) % N_DIR;
            if (!found && ((i_traffic >> idx) & N_DIR'(1)) != '0) begin
                next_dir = DIR_W'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule : tl_rr_next

// File: rtl/traffic_light_ctrl.sv
// Moore traffic-light controller for N_DIR approaches with min/max green,
// fixed yellow and round-robin service that skips idle approaches.
// Optional all-red clearance phase: define TL_ALL_RED_EN.
// Ports:
//   clk                         system clock, rising edge
//   reset_n                     asynchronous active-low reset
//   i_traffic [N_DIR-1:0]       synchronised car-present sensors
//   o_light   [2*N_DIR-1:0]     lamp code per approach, bits [2k+1:2k]
//   o_cur_dir [$clog2(N_DIR)-1:0] approach owning green/yellow
//   o_phase   [1:0]             0=GREEN, 1=YELLOW, 2=ALL_RED
module traffic_light_ctrl
    import tl_pkg::*;
#(
    parameter int unsigned N_DIR     = 2,
    parameter int unsigned GREEN_MIN = 4,
    parameter int unsigned GREEN_MAX = 16,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALL_RED_T = 2,
    parameter int unsigned CNT_W     = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_DIR-1:0]           i_traffic,
    output logic [LIGHT_W*N_DIR-1:0]   o_light,
    output logic [$clog2(N_DIR)-1:0]   o_cur_dir,
    output logic [1:0]                 o_phase
);

    localparam int unsigned DIR_W   = $clog2(N_DIR);
    localparam int unsigned LAMPS_W = LIGHT_W * N_DIR;
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
`ifdef TL_ALL_RED_EN
    localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALL_RED_T - 1);
`endif

    // Elaboration-time parameter legality.
    if (N_DIR < 2 || N_DIR > 8) begin : g_bad_n_dir
        $error("traffic_light_ctrl: N_DIR=%0d outside 2..8", N_DIR);
    end
    if (GREEN_MIN < 1) begin : g_bad_green_min
        $error("traffic_light_ctrl: GREEN_MIN must be >= 1");
    end
    if (GREEN_MAX <= GREEN_MIN) begin : g_bad_green_max
        $error("traffic_light_ctrl: GREEN_MAX must exceed GREEN_MIN");
    end
    if (YELLOW_T < 1) begin : g_bad_yellow
        $error("traffic_light_ctrl: YELLOW_T must be >= 1");
    end
    if (ALL_RED_T < 1) begin : g_bad_all_red
        $error("traffic_light_ctrl: ALL_RED_T must be >= 1");
    end
    if (CNT_W < 1 || CNT_W > 32 ||
        64'(GREEN_MAX) > CNT_MAX || 64'(YELLOW_T) > CNT_MAX ||
        64'(ALL_RED_T) > CNT_MAX) begin : g_bad_cnt_w
        $error("traffic_light_ctrl: CNT_W=%0d too narrow for phase timer", CNT_W);
    end

    phase_t               phase_q, phase_d;
    logic [DIR_W-1:0]     cur_dir_q, cur_dir_d;
    logic [CNT_W-1:0]     timer_q, timer_d;
    logic [LAMPS_W-1:0]   light_q, light_d;

    logic [DIR_W-1:0]     next_dir;
    logic                 cur_busy;
    logic                 green_done;
    logic [CNT_W-1:0]     timer_inc;

    tl_rr_next #(
        .N_DIR (N_DIR)
    ) u_rr_next (
        .i_traffic (i_traffic),
        .cur_dir   (cur_dir_q),
        .next_dir  (next_dir)
    );

    // Green ends once the minimum is served and the owner is idle, or at the cap.
    always_comb begin
        cur_busy   = (i_traffic & (N_DIR'(1) << cur_dir_q)) != '0;
        green_done = ((timer_q >= GMIN_M1) && !cur_busy) || (timer_q == GMAX_M1);
        timer_inc  = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);
    end

    // Next-state logic; any unused phase code recovers to the reset state.
    always_comb begin
        phase_d   = phase_q;
        cur_dir_d = cur_dir_q;
        timer_d   = timer_inc;
        case (phase_q)
            PH_GREEN: begin
                if (green_done) begin
                    phase_d = PH_YELLOW;
                    timer_d = '0;
                end
            end
            PH_YELLOW: begin
                if (timer_q == YEL_M1) begin
                    timer_d = '0;
`ifdef TL_ALL_RED_EN
                    phase_d = PH_ALL_RED;
`else
                    phase_d   = PH_GREEN;
                    cur_dir_d = next_dir;
`endif
                end
            end
`ifdef TL_ALL_RED_EN
            PH_ALL_RED: begin
                if (timer_q == AR_M1) begin
                    phase_d   = PH_GREEN;
                    cur_dir_d = next_dir;
                    timer_d   = '0;
                end
            end
`endif
            default: begin
                phase_d   = PH_GREEN;
                cur_dir_d = '0;
                timer_d   = '0;
            end
        endcase
    end

    // Lamp decode from the next state so o_light lines up with o_phase/o_cur_dir.
    always_comb begin
        light_d = {N_DIR{LIGHT_RED}};
        for (int unsigned k = 0; k < N_DIR; k++) begin
            if (DIR_W'(k) == cur_dir_d) begin
                if (phase_d == PH_GREEN) begin
                    light_d[LIGHT_W*k +: LIGHT_W] = LIGHT_GREEN;
                end else if (phase_d == PH_YELLOW) begin
                    light_d[LIGHT_W*k +: LIGHT_W] = LIGHT_YELLOW;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= PH_GREEN;
            cur_dir_q <= '0;
            timer_q   <= '0;
            light_q   <= {{(N_DIR-1){LIGHT_RED}}, LIGHT_GREEN};
        end else begin
            phase_q   <= phase_d;
            cur_dir_q <= cur_dir_d;
            timer_q   <= timer_d;
            light_q   <= light_d;
        end
    end

    assign o_light   = light_q;
    assign o_cur_dir = cur_dir_q;
    assign o_phase   = phase_q;

endmodule : traffic_light_ctrl

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl (N_DIR=2 and N_DIR=4 instances)
// and the standalone tl_rr_next selector.
module tb_traffic_light_ctrl;

`ifdef TL_ALL_RED_EN
    localparam int CLR = 3 + 2;
`else
    localparam int CLR = 3;
`endif

    logic       clk;
    logic       reset_n;
    logic [1:0] tr2;
    logic [3:0] light2;
    logic [0:0] cur2;
    logic [1:0] ph2;
    logic [3:0] tr4;
    logic [7:0] light4;
    logic [1:0] cur4;
    logic [1:0] ph4;
    logic [3:0] rr_tr;
    logic [1:0] rr_cur;
    logic [1:0] rr_next;

    int n_cmp = 0;
    int n_err = 0;

    traffic_light_ctrl #(.N_DIR(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .i_traffic(tr2),
        .o_light(light2), .o_cur_dir(cur2), .o_phase(ph2)
    );

    traffic_light_ctrl #(.N_DIR(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .i_traffic(tr4),
        .o_light(light4), .o_cur_dir(cur4), .o_phase(ph4)
    );

    tl_rr_next #(.N_DIR(4)) u_rr (
        .i_traffic(rr_tr), .cur_dir(rr_cur), .next_dir(rr_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset across one edge; returns #1 after an edge with reset released.
    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        #2;
        check_eq("rst_light2", 32'(light2), 32'h8);
        check_eq("rst_cur2",   32'(cur2),   32'h0);
        check_eq("rst_ph2",    32'(ph2),    32'h0);
        check_eq("rst_light4", 32'(light4), 32'hA8);
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    int v_cur [8] = '{0, 0, 3, 3, 1, 2, 1, 3};
    int v_tr  [8] = '{0, 4, 1, 0, 3, 15, 2, 8};
    int v_exp [8] = '{1, 2, 0, 0, 0, 3, 2, 0};

    initial begin
        reset_n = 1'b1;
        tr2     = '0;
        tr4     = '0;
        rr_tr   = '0;
        rr_cur  = '0;

        // Idle roads: 4 green, 3 yellow, then approach 1 green.
        tr2 = 2'b00;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_green", 32'(light2), 32'h8);
            step(1);
        end
        for (int i = 0; i < 3; i++) begin
            check_eq("t1_yellow", 32'(light2), 32'h9);
            check_eq("t1_ph_y",   32'(ph2),    32'h1);
            step(1);
        end
`ifdef TL_ALL_RED_EN
        for (int i = 0; i < 2; i++) begin
            check_eq("t1_allred", 32'(light2), 32'hA);
            check_eq("t1_ph_ar",  32'(ph2),    32'h2);
            step(1);
        end
`endif
        check_eq("t1_dir1_light", 32'(light2), 32'h2);
        check_eq("t1_dir1_cur",   32'(cur2),   32'h1);
        check_eq("t1_dir1_ph",    32'(ph2),    32'h0);

        // Held demand on approach 0: green capped at 16 cycles.
        tr2 = 2'b01;
        do_reset();
        step(15);
        check_eq("t2_green15", 32'(light2), 32'h8);
        step(1);
        check_eq("t2_yellow", 32'(light2), 32'h9);
        step(CLR);
        check_eq("t2_dir1_light", 32'(light2), 32'h2);
        check_eq("t2_dir1_cur",   32'(cur2),   32'h1);

        // Sensor drops at timer=1: green still lasts the 4-cycle minimum.
        tr2 = 2'b01;
        do_reset();
        step(1);
        tr2 = 2'b00;
        step(2);
        check_eq("t3_green_min", 32'(light2), 32'h8);
        step(1);
        check_eq("t3_yellow", 32'(light2), 32'h9);

        // Asynchronous reset during the second yellow cycle.
        tr2 = 2'b00;
        do_reset();
        step(5);
        check_eq("t4_in_yellow", 32'(ph2), 32'h1);
        reset_n = 1'b0;
        #2;
        check_eq("t4_async_light", 32'(light2), 32'h8);
        check_eq("t4_async_ph",    32'(ph2),    32'h0);
        check_eq("t4_async_cur",   32'(cur2),   32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(3);
        check_eq("t4_green4", 32'(light2), 32'h8);
        step(1);
        check_eq("t4_yellow", 32'(light2), 32'h9);

        // N_DIR=4: skip idle approach, wrap-around, no repeat of self.
        tr4 = 4'b0000;
        do_reset();
        tr4 = 4'b0100;
        step(4);
        check_eq("t5_yellow0", 32'(light4), 32'hA9);
        step(CLR);
        check_eq("t5_cur2",   32'(cur4),   32'h2);
        check_eq("t5_light2", 32'(light4), 32'h8A);
        tr4 = 4'b1000;
        step(4 + CLR);
        check_eq("t5_cur3",   32'(cur4),   32'h3);
        check_eq("t5_light3", 32'(light4), 32'h2A);
        tr4 = 4'b0001;
        step(4 + CLR);
        check_eq("t5_wrap0",  32'(cur4),   32'h0);
        check_eq("t5_light0", 32'(light4), 32'hA8);
        tr4 = 4'b0000;
        step(4);
        tr4 = 4'b0001;
        step(CLR);
        check_eq("t5_self_only", 32'(cur4), 32'h1);
        tr4 = 4'b0000;
        step(4);
        tr4 = 4'b1000;
        step(2);
        tr4 = 4'b0100;
        step(CLR - 2);
        check_eq("t5_exit_sample", 32'(cur4), 32'h2);

        // Standalone round-robin selector.
        for (int i = 0; i < 8; i++) begin
            rr_cur = 2'(v_cur[i]);
            rr_tr  = 4'(v_tr[i]);
            #1;
            check_eq($sformatf("rr_%0d", i), 32'(rr_next), 32'(v_exp[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_traffic_light_ctrl
